// File: rtl/piece_drop_ctrl.sv
// -----------------------------------------------------------------------------
// piece_drop_ctrl
//
// Game-side responder to the main game FSM. It tracks the row of the falling
// piece, runs the gravity drop timer, and reports lock ("placed") and spawn
// collision ("game_over") back to the main FSM. Board occupancy is evaluated
// elsewhere; this block only sees the two collision flags.
//
// Parameters:
//   ROWS        number of playfield rows; piece_row runs 0..ROWS-1
//   ROW_W       width of piece_row (2**ROW_W >= ROWS)
//   DROP_TICKS  in_clka cycles of FALL per gravity step (>= 2)
//
// Ports:
//   in_clka        in   1      system clock, rising edge
//   restart_n      in   1      asynchronous active-low reset
//   state          in   3      main FSM state code (0 IDLE, 1 SPAWN, 2 FALL,
//                              3 PLACE, 4 GAME_OVER; 5-7 behave as IDLE)
//   blocked_below  in   1      piece cannot move down from current row
//   spawn_blocked  in   1      spawn position (row 0) is occupied
//   piece_row      out  ROW_W  current row of the falling piece
//   drop_en        out  1      one-cycle pulse, same cycle piece_row increments
//   placed         out  1      one-cycle pulse when the piece locks
//   game_over      out  1      sticky level: spawn collided
// -----------------------------------------------------------------------------
module piece_drop_ctrl #(
  parameter int unsigned ROWS       = 16,
  parameter int unsigned ROW_W      = 4,
  parameter int unsigned DROP_TICKS = 8
) (
  input  logic             in_clka,
  input  logic             restart_n,
  input  logic [2:0]       state,
  input  logic             blocked_below,
  input  logic             spawn_blocked,
  output logic [ROW_W-1:0] piece_row,
  output logic             drop_en,
  output logic             placed,
  output logic             game_over
);

  localparam int unsigned TMR_W = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(DROP_TICKS - 1);

  // Main FSM state codes as seen on the state input.
  typedef enum logic [2:0] {
    CMD_IDLE  = 3'd0,
    CMD_SPAWN = 3'd1,
    CMD_FALL  = 3'd2,
    CMD_PLACE = 3'd3,
    CMD_OVER  = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    P_IDLE,
    P_CHK,
    P_FALL,
    P_LOCK,
    P_WAIT,
    P_DONE
  } pstate_e;

  cmd_e             cmd;
  pstate_e          pstate_q, pstate_d;
  logic [ROW_W-1:0] row_q,    row_d;
  logic [TMR_W-1:0] timer_q,  timer_d;
  logic             drop_q,   drop_d;
  logic             placed_q, placed_d;
  logic             over_q,   over_d;
  logic             tick;

  // Unused codes 5-7 fold onto IDLE so they hit the global override.
  always_comb begin
    cmd = CMD_IDLE;
    if (state <= 3'd4) begin
      cmd = cmd_e'(state);
    end
  end

  assign tick = (timer_q == LAST_TICK);

  always_ff @(posedge in_clka or negedge restart_n) begin
    if (!restart_n) begin
      pstate_q <= P_IDLE;
      row_q    <= '0;
      timer_q  <= '0;
      drop_q   <= 1'b0;
      placed_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      row_q    <= row_d;
      timer_q  <= timer_d;
      drop_q   <= drop_d;
      placed_q <= placed_d;
      over_q   <= over_d;
    end
  end

  // drop_en and placed are registered pulses: they are raised on the edge
  // that performs the row increment / the transition into P_LOCK, so each is
  // high exactly while the corresponding new state is visible.
  always_comb begin
    pstate_d = pstate_q;
    row_d    = row_q;
    timer_d  = timer_q;
    drop_d   = 1'b0;
    placed_d = 1'b0;
    over_d   = over_q;

    if (cmd == CMD_IDLE) begin
      pstate_d = P_IDLE;
      row_d    = '0;
      timer_d  = '0;
      over_d   = 1'b0;
    end else begin
      case (pstate_q)
        P_IDLE: begin
          if (cmd == CMD_SPAWN) begin
            pstate_d = P_CHK;
            row_d    = '0;
            timer_d  = '0;
          end
        end

        P_CHK: begin
          if (spawn_blocked) begin
            pstate_d = P_DONE;
            over_d   = 1'b1;
          end else begin
            pstate_d = P_FALL;
          end
        end

        P_FALL: begin
          if (cmd == CMD_OVER) begin
            pstate_d = P_DONE;
          end else if (cmd == CMD_FALL) begin
            if (tick) begin
              timer_d = '0;
              if (blocked_below || (row_q == LAST_ROW)) begin
                pstate_d = P_LOCK;
                placed_d = 1'b1;
              end else begin
                row_d  = row_q + 1'b1;
                drop_d = 1'b1;
              end
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
          // SPAWN / PLACE codes while falling: hold row and timer.
        end

        P_LOCK: begin
          pstate_d = P_WAIT;
        end

        P_WAIT: begin
          if (cmd == CMD_PLACE) begin
            pstate_d = P_IDLE;
          end else if (cmd == CMD_SPAWN) begin
            pstate_d = P_CHK;
            row_d    = '0;
            timer_d  = '0;
          end
        end

        P_DONE: begin
          // Sticky until state 0 or reset.
        end

        default: begin
          pstate_d = P_IDLE;
          row_d    = '0;
          timer_d  = '0;
        end
      endcase
    end
  end

  assign piece_row = row_q;
  assign drop_en   = drop_q;
  assign placed    = placed_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_piece_drop_ctrl.sv
`timescale 1ns/1ps
module tb_piece_drop_ctrl;

  localparam int ROWS = 16;
  localparam int ROW_W = 4;
  localparam int DT = 8;

  logic             clk = 1'b0;
  logic             restart_n = 1'b0;
  logic [2:0]       state = 3'd0;
  logic             blocked_below = 1'b0;
  logic             spawn_blocked = 1'b0;
  logic [ROW_W-1:0] piece_row;
  logic             drop_en;
  logic             placed;
  logic             game_over;

  piece_drop_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W), .DROP_TICKS(DT)) dut (
    .in_clka      (clk),
    .restart_n    (restart_n),
    .state        (state),
    .blocked_below(blocked_below),
    .spawn_blocked(spawn_blocked),
    .piece_row    (piece_row),
    .drop_en      (drop_en),
    .placed       (placed),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cnt_drop = 0;
  int cnt_placed = 0;

  // Reference model: phase of the piece's life, row, and count of FALL
  // cycles since the last gravity step.
  localparam int PH_IDLE = 0, PH_CHK = 1, PH_FALL = 2, PH_LOCK = 3,
                 PH_WAIT = 4, PH_DONE = 5;
  int  ph = PH_IDLE;
  int  m_row = 0;
  int  m_elapsed = 0;
  bit  m_drop = 0, m_placed = 0, m_over = 0;

  task automatic model_reset();
    ph = PH_IDLE; m_row = 0; m_elapsed = 0;
    m_drop = 0; m_placed = 0; m_over = 0;
  endtask

  task automatic model_edge(input int st, input bit bb, input bit sb);
    int s;
    s = (st > 4) ? 0 : st;
    m_drop = 0;
    m_placed = 0;
    if (s == 0) begin
      model_reset();
      return;
    end
    case (ph)
      PH_IDLE: if (s == 1) begin ph = PH_CHK; m_row = 0; m_elapsed = 0; end
      PH_CHK: begin
        if (sb) begin ph = PH_DONE; m_over = 1; end
        else ph = PH_FALL;
      end
      PH_FALL: begin
        if (s == 4) ph = PH_DONE;
        else if (s == 2) begin
          m_elapsed++;
          if (m_elapsed == DT) begin
            m_elapsed = 0;
            if (bb || m_row == ROWS - 1) begin ph = PH_LOCK; m_placed = 1; end
            else begin m_row++; m_drop = 1; end
          end
        end
      end
      PH_LOCK: ph = PH_WAIT;
      PH_WAIT: begin
        if (s == 3) ph = PH_IDLE;
        else if (s == 1) begin ph = PH_CHK; m_row = 0; m_elapsed = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag);
    logic [ROW_W-1:0] exp_row;
    exp_row = ROW_W'(m_row);
    vectors++;
    cnt_drop += int'(drop_en);
    cnt_placed += int'(placed);
    assert (piece_row === exp_row) else begin
      miscompares++;
      $error("FAIL %s piece_row: got %0d expected %0d", tag, piece_row, exp_row);
    end
    assert (drop_en === m_drop) else begin
      miscompares++;
      $error("FAIL %s drop_en: got %b expected %b", tag, drop_en, m_drop);
    end
    assert (placed === m_placed) else begin
      miscompares++;
      $error("FAIL %s placed: got %b expected %b", tag, placed, m_placed);
    end
    assert (game_over === m_over) else begin
      miscompares++;
      $error("FAIL %s game_over: got %b expected %b", tag, game_over, m_over);
    end
    assert (!(drop_en === 1'b1 && placed === 1'b1)) else begin
      miscompares++;
      $error("FAIL %s exclusive: drop_en=%b placed=%b expected not both 1", tag, drop_en, placed);
    end
  endtask

  task automatic cyc(input int st, input bit bb, input bit sb, input string tag);
    @(negedge clk);
    state = 3'(st);
    blocked_below = bb;
    spawn_blocked = sb;
    @(posedge clk);
    model_edge(st, bb, sb);
    #1;
    check(tag);
  endtask

  task automatic expect_count(input string tag, input int got, input int exp);
    vectors++;
    assert (got == exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int st;
    int r;

    // Reset state
    #1;
    model_reset();
    check("reset");
    @(negedge clk);
    restart_n = 1'b1;
    cyc(2, 0, 0, "idle_hold");

    // Free fall to the bottom
    cyc(1, 0, 0, "ff_spawn");
    cnt_drop = 0; cnt_placed = 0;
    repeat (1 + ROWS * DT + 5) cyc(2, 0, 0, "ff_fall");
    expect_count("ff_drops", cnt_drop, ROWS - 1);
    expect_count("ff_placed", cnt_placed, 1);
    expect_count("ff_row", int'(piece_row), ROWS - 1);
    cyc(3, 0, 0, "ff_ack");

    // Collision lock at row 6
    cyc(1, 0, 0, "col_spawn");
    for (int i = 0; i < 200 && m_row != 6; i++) cyc(2, 0, 0, "col_fall");
    cnt_drop = 0; cnt_placed = 0;
    repeat (DT + 3) cyc(2, 1, 0, "col_block");
    expect_count("col_drops", cnt_drop, 0);
    expect_count("col_placed", cnt_placed, 1);
    expect_count("col_row", int'(piece_row), 6);
    cyc(3, 0, 0, "col_ack");
    cyc(1, 0, 0, "col_respawn");
    expect_count("col_respawn_row", int'(piece_row), 0);

    // Spawn blocked -> sticky game_over
    cyc(0, 0, 0, "sb_clear");
    cyc(1, 0, 1, "sb_spawn");
    cyc(2, 0, 1, "sb_chk");
    cyc(2, 0, 0, "sb_st2");
    cyc(3, 0, 0, "sb_st3");
    cyc(4, 0, 0, "sb_st4");
    expect_count("sb_over_held", int'(game_over), 1);
    cyc(0, 0, 0, "sb_release");
    expect_count("sb_over_cleared", int'(game_over), 0);

    // Hold with SPAWN code, then state 0 on a tick edge
    cyc(1, 0, 0, "hold_spawn");
    for (int i = 0; i < 200 && m_row != 3; i++) cyc(2, 0, 0, "hold_fall");
    repeat (3) cyc(2, 0, 0, "hold_mid");
    cnt_drop = 0;
    repeat (20) cyc(1, 0, 0, "hold_frozen");
    expect_count("hold_drops", cnt_drop, 0);
    expect_count("hold_row", int'(piece_row), 3);
    cnt_drop = 0;
    repeat (DT - 3) cyc(2, 0, 0, "hold_resume");
    expect_count("hold_resume_drop", cnt_drop, 1);
    for (int i = 0; i < 20 && m_elapsed != DT - 1; i++) cyc(2, 0, 0, "hold_to_tick");
    cyc(0, 0, 0, "hold_abort_tick");

    // Back-to-back spawn without PLACE
    cnt_placed = 0; cnt_drop = 0;
    cyc(1, 0, 0, "b2b_spawn");
    repeat (1 + DT) cyc(2, 1, 0, "b2b_lock");
    repeat (3) cyc(2, 0, 0, "b2b_wait");
    cyc(1, 0, 0, "b2b_respawn");
    expect_count("b2b_row", int'(piece_row), 0);
    repeat (1 + DT + 1) cyc(2, 0, 0, "b2b_fall");
    expect_count("b2b_placed", cnt_placed, 1);
    expect_count("b2b_drops", cnt_drop, 1);

    // Asynchronous reset mid-fall
    cyc(0, 0, 0, "ar_clear");
    cyc(1, 0, 0, "ar_spawn");
    for (int i = 0; i < 200 && m_row != 5; i++) cyc(2, 0, 0, "ar_fall");
    repeat (3) cyc(2, 0, 0, "ar_mid");
    @(negedge clk);
    #2 restart_n = 1'b0;
    #1;
    model_reset();
    check("ar_async");
    @(negedge clk);
    restart_n = 1'b1;
    repeat (DT + 2) cyc(2, 0, 0, "ar_idle");
    cyc(1, 0, 0, "ar_respawn");

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       st = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 7);
      else if (r < 15) st = 1;
      else if (r < 80) st = 2;
      else if (r < 92) st = 3;
      else             st = 4;
      cyc(st, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piece_drop_ctrl.md
Name: piece_drop_ctrl

Overview:
Game-side responder to the main game FSM. It tracks the falling piece's row and runs the gravity drop timer. It generates the placed and game_over status inputs the main FSM consumes, and follows the FSM's 3-bit state code. Board occupancy checks are done externally; this block sees them only as two collision flags.

Parameters:
ROWS, 16, number of playfield rows; piece_row runs 0..ROWS-1
ROW_W, 4, width of piece_row; must satisfy 2^ROW_W >= ROWS
DROP_TICKS, 8, in_clka cycles per gravity step; minimum 2

Ports:
in_clka  input  1  system clock, rising edge
restart_n  input  1  asynchronous active-low reset
state  input  3  main FSM state: 0 IDLE, 1 SPAWN, 2 FALL, 3 PLACE, 4 GAME_OVER; codes 5-7 are treated as 0
blocked_below  input  1  piece cannot move down from current piece_row
spawn_blocked  input  1  spawn position (row 0) is occupied
piece_row  output  ROW_W  current row of the falling piece
drop_en  output  1  one-cycle pulse in the same cycle piece_row increments
placed  output  1  one-cycle pulse: piece has locked
game_over  output  1  level: spawn collided; sticky

Behaviour:
- All outputs are registered. When restart_n is low (asynchronous): piece_row=0, drop_en=0, placed=0, game_over=0, timer=0, internal state P_IDLE.
- Global override, synchronous, highest priority: state==0 (or 5-7) on any edge -> P_IDLE, piece_row=0, timer=0, drop_en=0, placed=0, game_over=0.
- Internal FSM states: P_IDLE, P_CHK, P_FALL, P_LOCK, P_WAIT, P_DONE.
- P_IDLE:
  - state==1 -> P_CHK; piece_row=0, timer=0.
  - Any other code: stay.
- P_CHK (exactly 1 cycle):
  - spawn_blocked=1 -> P_DONE, game_over=1 on the next edge.
  - Otherwise -> P_FALL.
- P_FALL:
  - The timer counts only while state==2. While state==1, the block holds: timer and row frozen.
  - On a tick (timer==DROP_TICKS-1): timer=0.
    - If blocked_below=1 or piece_row==ROWS-1 -> P_LOCK.
    - Otherwise piece_row+1 and drop_en=1 for that one cycle.
  - blocked_below is sampled only on tick cycles.
  - state==4 -> P_DONE, game_over unchanged.
- P_LOCK (1 cycle): placed=1 for exactly one cycle -> P_WAIT. piece_row holds the lock row.
- P_WAIT: wait for the main FSM to acknowledge.
  - state==3 -> P_IDLE.
  - state==1 -> P_CHK directly (back-to-back spawn); piece_row=0, timer=0.
  - placed is never re-asserted while waiting.
- P_DONE: game_over held at 1. Leave only via state==0 or reset. No drop_en and no placed in this state.
- Latency:
  - Spawn to first drop_en = 1 (P_CHK) + DROP_TICKS cycles of state==2.
  - Lock from row r with no blocking: placed arrives DROP_TICKS cycles after the drop_en into ROWS-1.
- Simultaneous events:
  - Reset beats everything.
  - state==0 beats a tick.
  - A tick with blocked_below=1 at row ROWS-1 locks once, with a single placed pulse.
- piece_row never exceeds ROWS-1; there is no wrap-around.
- drop_en and placed are never high in the same cycle.

Test Plan:
- Reset mid-fall: assert restart_n=0 asynchronously at row 5, mid-timer -> all outputs 0 immediately, before the next edge; after release the block stays in P_IDLE until state==1.
- Free fall: state=1 for 1 cycle, then state=2, blocked flags 0 -> drop_en every 8 cycles, piece_row counts 1..15; placed pulses once 8 cycles after row 15; no drop_en past 15.
- Collision lock: during fall set blocked_below=1 when piece_row==6 -> at the next tick placed=1 for one cycle, piece_row stays 6, no drop_en. Then drive state=3 -> P_IDLE; then state=1 -> piece_row=0.
- Spawn blocked: spawn_blocked=1, state=1 -> game_over=1 two edges later and stays 1 through states 2/3/4; drive state=0 -> game_over=0 next edge.
- Abort and hold: at row 3 drive state=1 for 20 cycles -> no drop_en, row and timer frozen; back to state=2 resumes mid-timer. Then drive state=0 on a tick edge -> piece_row=0, drop_en=0.
- Back-to-back spawn: after placed, go directly to state=1 with no PLACE -> P_CHK, piece_row=0, a single placed pulse total, and the next fall proceeds normally.
